sad_select_sequencer: RTL and testbench

- Sequences the SAD competition writeback path.
- On a start command it captures the eight SAD results arriving with the WB-stage signals and writes them one per cycle into the SAD register file.
- While writing, it scans the values for the minimum or maximum, reports the winning value and index, and issues a one-cycle write of the winner to the min register.
- It holds the pipeline stalled for the whole sequence.

---
 rtl/sad_select_sequencer_if.sv | 32 +++
 rtl/sad_select_sequencer.sv | 108 ++++++++++
 tb/tb_sad_select_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sad_select_sequencer_if.sv
// SAD select sequencer bus: start/capture inputs plus
// register-file write, winner and status outputs.
interface sad_select_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SAD = 8,
    parameter int IDX_W   = 3
);
    logic                        start;
    logic                        find_max;
    logic [NUM_SAD*DATA_W-1:0]   sad_in;
    logic                        busy;
    logic                        stall_req;
    logic                        sad_we;
    logic [IDX_W-1:0]            sad_waddr;
    logic [DATA_W-1:0]           sad_wdata;
    logic                        min_we;
    logic [DATA_W-1:0]           best_value;
    logic [IDX_W-1:0]            best_index;
    logic                        done;

    modport master (
        output start, find_max, sad_in,
        input  busy, stall_req, sad_we, sad_waddr, sad_wdata,
        input  min_we, best_value, best_index, done
    );

    modport slave (
        input  start, find_max, sad_in,
        output busy, stall_req, sad_we, sad_waddr, sad_wdata,
        output min_we, best_value, best_index, done
    );
endinterface

// File: rtl/sad_select_sequencer.sv
// Captures NUM_SAD SAD results, writes them out one per cycle
// and tracks the min/max winner while holding the pipeline.
module sad_select_sequencer #(
    parameter int DATA_W  = 32,
    parameter int NUM_SAD = 8,
    parameter int IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    sad_select_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SAD - 1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_buf [NUM_SAD];
    logic [IDX_W-1:0]  r_cnt;
    logic              r_max;
    logic [DATA_W-1:0] r_best_val;
    logic [IDX_W-1:0]  r_best_idx;

    logic [DATA_W-1:0] w_cur;
    logic              w_better;
    logic              w_last;

    assign w_cur    = r_buf[r_cnt];
    assign w_last   = (r_cnt == LAST);
    // Strict compare so an equal later value never displaces an earlier one
    assign w_better = r_max ? (w_cur > r_best_val) : (w_cur < r_best_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.busy       = 1'b0;
        bus.stall_req  = 1'b0;
        bus.sad_we     = 1'b0;
        bus.sad_waddr  = '0;
        bus.sad_wdata  = '0;
        bus.min_we     = 1'b0;
        bus.done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = SCAN;
            end
            SCAN: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                bus.sad_we    = 1'b1;
                bus.sad_waddr = r_cnt;
                bus.sad_wdata = w_cur;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                bus.min_we    = 1'b1;
                bus.done      = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SAD; k++) r_buf[k] <= '0;
            r_cnt      <= '0;
            r_max      <= 1'b0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < NUM_SAD; k++)
                            r_buf[k] <= bus.sad_in[k*DATA_W +: DATA_W];
                        r_max <= bus.find_max;
                        r_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '0 || w_better) begin
                        r_best_val <= w_cur;
                        r_best_idx <= r_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.best_value = r_best_val;
    assign bus.best_index = r_best_idx;
endmodule

// File: tb/tb_sad_select_sequencer.sv
// Scoreboard bench: stimulus queues expected writes/results,
// a negedge monitor pops and compares as the DUT presents them.
module tb_sad_select_sequencer;
    localparam int DW = 32;
    localparam int NS = 8;
    localparam int IW = 3;

    typedef logic [NS-1:0][DW-1:0] vec_t;

    typedef struct packed {
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [IW-1:0] idx;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wr_t  wq [$];
    res_t rq [$];

    sad_select_sequencer_if #(.DATA_W(DW), .NUM_SAD(NS), .IDX_W(IW)) bus ();

    sad_select_sequencer #(.DATA_W(DW), .NUM_SAD(NS), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("stall_eq_busy", 64'(bus.stall_req), 64'(bus.busy));
        if (bus.sad_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_sad_we", 64'(bus.sad_waddr), 64'hFFFF);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("sad_waddr", 64'(bus.sad_waddr), 64'(w.addr));
                chk("sad_wdata", 64'(bus.sad_wdata), 64'(w.data));
            end
        end
        if (bus.done) begin
            chk("min_we_with_done", 64'(bus.min_we), 64'd1);
            if (rq.size() == 0) begin
                chk("unexpected_done", 64'(bus.best_value), 64'hFFFF);
            end else begin
                res_t r;
                r = rq.pop_front();
                chk("best_value", 64'(bus.best_value), 64'(r.val));
                chk("best_index", 64'(bus.best_index), 64'(r.idx));
            end
        end else begin
            chk("min_we_without_done", 64'(bus.min_we), 64'd0);
        end
    end

    task automatic push_writes(input vec_t v, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = IW'(k);
            w.data = v[k];
            wq.push_back(w);
        end
    endtask

    task automatic launch(input vec_t v, input logic fm);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.sad_in   = v;
        bus.find_max = fm;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input bit check_len);
        int n;
        n = 0;
        while (bus.busy && n < 30) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 30) chk("busy_timeout", 64'(n), 64'd9);
        else if (check_len) chk("busy_cycles", 64'(n), 64'd9);
    endtask

    task automatic run_seq(input vec_t v, input logic fm,
                           input logic [DW-1:0] bv, input logic [IW-1:0] bi);
        res_t r;
        push_writes(v, NS);
        r.val = bv;
        r.idx = bi;
        rq.push_back(r);
        launch(v, fm);
        wait_idle(1'b1);
    endtask

    vec_t v_min, v_tie, v_ign, v_rst, v_ones, v_zero;

    initial begin
        bus.start    = 1'b1;
        bus.find_max = 1'b0;
        bus.sad_in   = '1;
        v_min  = {32'd40, 32'd12, 32'd99, 32'd12,
                  32'd50, 32'd8, 32'd300, 32'd25};
        v_tie  = {32'd0, 32'd0, 32'd0, 32'd0,
                  32'd1, 32'd900, 32'd900, 32'd5};
        v_ign  = {32'd2, 32'd20, 32'd1, 32'd1,
                  32'd3, 32'd9, 32'd3, 32'd7};
        v_rst  = {32'd80, 32'd70, 32'd60, 32'd50,
                  32'd40, 32'd30, 32'd20, 32'd10};
        v_ones = '1;
        v_zero = '0;

        // reset held with start high
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_sad_we", 64'(bus.sad_we), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_best_value", 64'(bus.best_value), 64'd0);
            chk("rst_best_index", 64'(bus.best_index), 64'd0);
            chk("rst_waddr_wdata", 64'(bus.sad_wdata) | 64'(bus.sad_waddr), 64'd0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        run_seq(v_min, 1'b0, 32'd8, 3'd2);
        chk("hold_value_idle", 64'(bus.best_value), 64'd8);
        run_seq(v_tie, 1'b1, 32'd900, 3'd1);

        // start re-pulse and input change during SCAN i=3
        begin
            res_t r;
            push_writes(v_ign, NS);
            r.val = 32'd1;
            r.idx = 3'd4;
            rq.push_back(r);
            launch(v_ign, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            bus.start    = 1'b1;
            bus.sad_in   = '0;
            bus.find_max = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_idle(1'b0);
        end
        run_seq(v_ign, 1'b1, 32'd20, 3'd6);

        // reset during SCAN i=4
        push_writes(v_rst, 5);
        launch(v_rst, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sad_we", 64'(bus.sad_we), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_best_value", 64'(bus.best_value), 64'd0);
        chk("midrst_best_index", 64'(bus.best_index), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        run_seq(v_ones, 1'b0, 32'hFFFF_FFFF, 3'd0);
        run_seq(v_zero, 1'b1, 32'd0, 3'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("writes_left", 64'(wq.size()), 64'd0);
        chk("results_left", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
